// File: rtl/controle_irrigacao_if.sv
// Sensor and actuator bundle of the irrigation controller.
// The controller takes the slave side; the plant/bench takes master.
interface controle_irrigacao_if;
    logic       Us;
    logic       Ua;
    logic       T;
    logic       H;
    logic       M;
    logic       L;
    logic       Vs;
    logic       Bs;
    logic       Ve;
    logic       Al;
    logic       Cheio;
    logic       Medio;
    logic       Baixo;
    logic       Vazio;
    logic       Erro;
    logic [2:0] estado;

    modport master (
        output Us, Ua, T, H, M, L,
        input  Vs, Bs, Ve, Al,
        input  Cheio, Medio, Baixo, Vazio, Erro,
        input  estado
    );

    modport slave (
        input  Us, Ua, T, H, M, L,
        output Vs, Bs, Ve, Al,
        output Cheio, Medio, Baixo, Vazio, Erro,
        output estado
    );
endinterface

// File: rtl/controle_irrigacao.sv
// Irrigation controller: sensor sync/debounce, tank level decode,
// drip/sprinkler scheduler with run limits and dead time, inlet valve.
module controle_irrigacao #(
    parameter int DEB_CYC = 4,
    parameter int MIN_ON  = 16,
    parameter int MAX_ON  = 255,
    parameter int GAP     = 2,
    parameter int CNT_W   = 8
) (
    input  logic          clk,
    input  logic          rst,
    controle_irrigacao_if.slave io
);
    localparam int DW   = $clog2(DEB_CYC + 1);
    localparam int I_US = 5;
    localparam int I_UA = 4;
    localparam int I_T  = 3;
    localparam int I_H  = 2;
    localparam int I_M  = 1;
    localparam int I_L  = 0;

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        GOTEJA   = 3'd1,
        ASPERSAO = 3'd2,
        PAUSA    = 3'd3,
        FALHA    = 3'd4
    } state_t;

    logic [5:0]    raw;
    logic [5:0]    sync1;
    logic [5:0]    sync2;
    logic [5:0]    deb;
    logic [DW-1:0] debCnt [6];

    logic cheio;
    logic medio;
    logic baixo;
    logic vazio;
    logic erro;
    logic usR;
    logic uaR;
    logic tR;

    logic reqG;
    logic reqA;
    logic ownReq;

    state_t           state;
    state_t           stateNxt;
    logic [CNT_W-1:0] tmr;
    logic [CNT_W-1:0] tmrNxt;
    logic             setTmo;
    logic             tmo;
    logic             veR;

    assign raw = {io.Us, io.Ua, io.T, io.H, io.M, io.L};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // A change is accepted on the DEB_CYC-th consecutive differing sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb <= '0;
            for (int i = 0; i < 6; i++) debCnt[i] <= '0;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (sync2[i] == deb[i]) begin
                    debCnt[i] <= '0;
                end else if (debCnt[i] == DW'(DEB_CYC - 1)) begin
                    debCnt[i] <= '0;
                    deb[i]    <= sync2[i];
                end else begin
                    debCnt[i] <= debCnt[i] + 1'b1;
                end
            end
        end
    end

    // Weather sensors are staged alongside the level flags so that
    // every sensor sees the same latency into the scheduler.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cheio <= 1'b0;
            medio <= 1'b0;
            baixo <= 1'b0;
            vazio <= 1'b1;
            erro  <= 1'b0;
            usR   <= 1'b0;
            uaR   <= 1'b0;
            tR    <= 1'b0;
        end else begin
            cheio <= deb[I_H] & deb[I_M] & deb[I_L];
            medio <= ~deb[I_H] & deb[I_M] & deb[I_L];
            baixo <= ~deb[I_H] & ~deb[I_M] & deb[I_L];
            vazio <= ~deb[I_H] & ~deb[I_M] & ~deb[I_L];
            erro  <= (deb[I_M] & ~deb[I_L])
                   | (deb[I_H] & ~deb[I_M]);
            usR   <= deb[I_US];
            uaR   <= deb[I_UA];
            tR    <= deb[I_T];
        end
    end

    assign reqG = ~usR & uaR & ~erro & ~vazio
                & (tR | baixo);
    assign reqA = ~usR & ~erro & ~vazio
                & (~uaR | (~tR & medio));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OCIOSO;
            tmr   <= '0;
        end else begin
            state <= stateNxt;
            tmr   <= tmrNxt;
        end
    end

    always_comb begin
        stateNxt = state;
        tmrNxt   = tmr;
        setTmo   = 1'b0;
        ownReq   = 1'b0;
        unique case (state)
            OCIOSO: begin
                if (erro)      stateNxt = FALHA;
                else if (reqG) stateNxt = GOTEJA;
                else if (reqA) stateNxt = ASPERSAO;
            end
            GOTEJA, ASPERSAO: begin
                tmrNxt = tmr + 1'b1;
                ownReq = (state == GOTEJA) ? reqG : reqA;
                if (erro) begin
                    stateNxt = FALHA;
                end else if (vazio) begin
                    stateNxt = PAUSA;
                end else if (tmr == CNT_W'(MAX_ON - 1)) begin
                    stateNxt = PAUSA;
                    setTmo   = 1'b1;
                end else if (!ownReq
                          && tmr >= CNT_W'(MIN_ON - 1)) begin
                    stateNxt = PAUSA;
                end
            end
            PAUSA: begin
                tmrNxt = tmr + 1'b1;
                if (tmr == CNT_W'(GAP - 1))
                    stateNxt = erro ? FALHA : OCIOSO;
            end
            FALHA: begin
                if (!erro) stateNxt = PAUSA;
            end
            default: stateNxt = OCIOSO;
        endcase
        // Every state entry restarts the shared run/gap timer
        if (stateNxt != state) tmrNxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         tmo <= 1'b0;
        else if (setTmo) tmo <= 1'b1;
        else if (deb[I_US]) tmo <= 1'b0;
    end

    // Clear wins over set; Medio falls through and holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            veR <= 1'b0;
        else if (cheio || erro || state == FALHA)
            veR <= 1'b0;
        else if (vazio || baixo)
            veR <= 1'b1;
    end

    assign io.Vs     = (state == GOTEJA);
    assign io.Bs     = (state == ASPERSAO);
    assign io.Ve     = veR;
    assign io.Al     = ~deb[I_M] | ~deb[I_L] | erro | tmo;
    assign io.Cheio  = cheio;
    assign io.Medio  = medio;
    assign io.Baixo  = baixo;
    assign io.Vazio  = vazio;
    assign io.Erro   = erro;
    assign io.estado = state;
endmodule

// File: tb/tb_controle_irrigacao.sv
// Scoreboard bench for controle_irrigacao: stimulus queues
// cycle-tagged expectations, a monitor retires them at negedge.
module tb_controle_irrigacao;
    localparam int S_EST = 0;
    localparam int S_VS  = 1;
    localparam int S_BS  = 2;
    localparam int S_VE  = 3;
    localparam int S_AL  = 4;
    localparam int S_CH  = 5;
    localparam int S_ME  = 6;
    localparam int S_BA  = 7;
    localparam int S_VA  = 8;
    localparam int S_ER  = 9;

    typedef struct {
        int cyc;
        int sel;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc    = 0;
    int   nTests = 0;
    int   nFail  = 0;
    int   idx;
    exp_t pend[$];

    controle_irrigacao_if bus();

    controle_irrigacao #(
        .DEB_CYC(4),
        .MIN_ON (16),
        .MAX_ON (255),
        .GAP    (2),
        .CNT_W  (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string sigName(int sel);
        case (sel)
            S_EST:   return "estado";
            S_VS:    return "Vs";
            S_BS:    return "Bs";
            S_VE:    return "Ve";
            S_AL:    return "Al";
            S_CH:    return "Cheio";
            S_ME:    return "Medio";
            S_BA:    return "Baixo";
            S_VA:    return "Vazio";
            S_ER:    return "Erro";
            default: return "unknown";
        endcase
    endfunction

    function automatic int getSig(int sel);
        case (sel)
            S_EST:   return int'(bus.estado);
            S_VS:    return int'(bus.Vs);
            S_BS:    return int'(bus.Bs);
            S_VE:    return int'(bus.Ve);
            S_AL:    return int'(bus.Al);
            S_CH:    return int'(bus.Cheio);
            S_ME:    return int'(bus.Medio);
            S_BA:    return int'(bus.Baixo);
            S_VA:    return int'(bus.Vazio);
            S_ER:    return int'(bus.Erro);
            default: return -1;
        endcase
    endfunction

    task automatic check(string name, int act, int expv);
        nTests++;
        if (act !== expv) begin
            nFail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d",
                     name, cyc, act, expv);
        end
    endtask

    function automatic void ex(int c, int sel, int v);
        exp_t e;
        e.cyc = c;
        e.sel = sel;
        e.val = v;
        pend.push_back(e);
    endfunction

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            idx = 0;
            while (idx < pend.size()) begin
                if (pend[idx].cyc == cyc) begin
                    check(sigName(pend[idx].sel),
                          getSig(pend[idx].sel),
                          pend[idx].val);
                    pend.delete(idx);
                end else if (pend[idx].cyc < cyc) begin
                    check({sigName(pend[idx].sel), "_missed"},
                          0, 1);
                    pend.delete(idx);
                end else begin
                    idx++;
                end
            end
            check("VsBsExclusive", int'(bus.Vs & bus.Bs), 0);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: run exceeded 20000 cycles");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        rst    = 1'b1;
        bus.Us = 1'b1;
        bus.Ua = 1'b0;
        bus.T  = 1'b0;
        bus.H  = 1'b0;
        bus.M  = 1'b0;
        bus.L  = 1'b0;
        step(2);
        // reset state
        t = cyc;
        ex(t + 1, S_EST, 0); ex(t + 1, S_VS, 0);
        ex(t + 1, S_BS, 0);  ex(t + 1, S_VE, 0);
        ex(t + 1, S_AL, 1);  ex(t + 1, S_VA, 1);
        ex(t + 1, S_CH, 0);  ex(t + 1, S_ER, 0);
        step(1);
        rst = 1'b0;
        t = cyc;
        ex(t + 1, S_VE, 1);  ex(t + 1, S_VA, 1);
        ex(t + 1, S_AL, 1);  ex(t + 1, S_EST, 0);
        // tank fill: L, then M, then H
        step(2);
        bus.L = 1'b1;
        t = cyc;
        ex(t + 6, S_BA, 0);  ex(t + 7, S_BA, 1);
        ex(t + 7, S_VA, 0);  ex(t + 8, S_VE, 1);
        step(10);
        bus.M = 1'b1;
        t = cyc;
        ex(t + 5, S_AL, 1);  ex(t + 6, S_AL, 0);
        ex(t + 7, S_ME, 1);  ex(t + 8, S_VE, 1);
        step(10);
        bus.H = 1'b1;
        t = cyc;
        ex(t + 7, S_VE, 1);  ex(t + 8, S_VE, 0);
        ex(t + 7, S_CH, 1);  ex(t + 7, S_ME, 0);
        // back to Medio: inlet holds closed
        step(10);
        bus.H = 1'b0;
        t = cyc;
        ex(t + 7, S_ME, 1);  ex(t + 8, S_VE, 0);
        // drip request, then T drops; sprinkler follows
        step(10);
        bus.Us = 1'b0;
        bus.Ua = 1'b1;
        bus.T  = 1'b1;
        t = cyc;
        ex(t + 7, S_VS, 0);   ex(t + 8, S_VS, 1);
        ex(t + 8, S_EST, 1);  ex(t + 23, S_VS, 1);
        ex(t + 24, S_VS, 0);  ex(t + 24, S_EST, 3);
        ex(t + 25, S_EST, 3); ex(t + 26, S_EST, 0);
        ex(t + 26, S_BS, 0);  ex(t + 27, S_BS, 1);
        ex(t + 27, S_EST, 2);
        step(11);
        bus.T = 1'b0;
        // soil ok and tank full stop the sprinkler
        step(29);
        bus.Us = 1'b1;
        bus.H  = 1'b1;
        t = cyc;
        ex(t + 7, S_BS, 1);   ex(t + 8, S_BS, 0);
        ex(t + 8, S_EST, 3);  ex(t + 10, S_EST, 0);
        ex(t + 7, S_CH, 1);   ex(t + 8, S_VE, 0);
        step(12);
        bus.Us = 1'b0;
        // 3-cycle Ua glitch must be filtered
        step(10);
        bus.Ua = 1'b0;
        t = cyc;
        ex(t + 8, S_EST, 0);  ex(t + 8, S_BS, 0);
        ex(t + 9, S_BS, 0);   ex(t + 12, S_EST, 0);
        ex(t + 12, S_BS, 0);
        step(3);
        bus.Ua = 1'b1;
        // drip held past MAX_ON
        step(13);
        bus.T = 1'b1;
        t = cyc;
        ex(t + 7, S_VS, 0);    ex(t + 8, S_VS, 1);
        ex(t + 262, S_VS, 1);  ex(t + 263, S_VS, 0);
        ex(t + 262, S_AL, 0);  ex(t + 263, S_AL, 1);
        ex(t + 263, S_EST, 3); ex(t + 265, S_VS, 0);
        ex(t + 266, S_VS, 1);  ex(t + 266, S_AL, 1);
        ex(t + 281, S_VS, 1);  ex(t + 282, S_VS, 0);
        step(270);
        bus.Us = 1'b1;
        t = cyc;
        ex(t + 6, S_AL, 1);    ex(t + 7, S_AL, 0);
        // sprinkler, then probe fault M=1 L=0
        step(20);
        bus.Us = 1'b0;
        bus.Ua = 1'b0;
        bus.T  = 1'b0;
        t = cyc;
        ex(t + 8, S_BS, 1);    ex(t + 8, S_EST, 2);
        step(10);
        bus.H = 1'b0;
        bus.L = 1'b0;
        t = cyc;
        ex(t + 5, S_AL, 0);    ex(t + 6, S_AL, 1);
        ex(t + 7, S_ER, 1);    ex(t + 7, S_BS, 1);
        ex(t + 8, S_BS, 0);    ex(t + 8, S_EST, 4);
        ex(t + 8, S_VE, 0);
        step(12);
        bus.L = 1'b1;
        t = cyc;
        ex(t + 6, S_AL, 1);    ex(t + 7, S_AL, 0);
        ex(t + 7, S_ER, 0);    ex(t + 7, S_ME, 1);
        ex(t + 7, S_EST, 4);   ex(t + 8, S_EST, 3);
        ex(t + 10, S_EST, 0);  ex(t + 11, S_EST, 2);
        ex(t + 11, S_BS, 1);   ex(t + 9, S_VE, 0);
        ex(t + 14, S_BS, 1);
        step(14);
        // asynchronous reset mid-run
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rstAsyncBs", int'(bus.Bs), 0);
        check("rstAsyncEstado", int'(bus.estado), 0);
        check("rstAsyncVazio", int'(bus.Vazio), 1);
        check("rstAsyncMedio", int'(bus.Medio), 0);
        check("rstAsyncAl", int'(bus.Al), 1);
        check("rstAsyncVe", int'(bus.Ve), 0);
        step(3);
        rst = 1'b0;
        t = cyc;
        ex(t + 1, S_VE, 1);    ex(t + 1, S_VA, 1);
        ex(t + 1, S_EST, 0);   ex(t + 1, S_AL, 1);
        for (int k = 0; k < 30 && pend.size() != 0; k++)
            step(1);
        if (pend.size() != 0) begin
            nTests++;
            nFail++;
            $display("FAIL drain: %0d expectations left",
                     pend.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule

// File: doc/controle_irrigacao.md
# controle_irrigacao

Sequential controller for the irrigation datapath. It debounces the soil, air, temperature and tank-level sensors, then schedules the drip valve (Vs) and the sprinkler (Bs) as mutually exclusive resources with minimum run time, timeout and dead time. It also drives the tank inlet valve (Ve) with hysteresis and raises the alarm. It replaces free-running combinational valve equations as the block that owns the valves.

## Interface
- DEB_CYC, 4: consecutive stable cycles required to accept a sensor change (≥1)
- MIN_ON, 16: minimum cycles a valve stays open once started (≥1)
- MAX_ON, 255: maximum cycles a valve stays open (timeout); MAX_ON > MIN_ON
- GAP, 2: dead-time cycles with both valves closed between runs (≥1)
- CNT_W, 8: width of the run/gap timers; 2^CNT_W > MAX_ON
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- Us, Ua, T  in  1 each  soil humidity ok, air humidity ok, high temperature (asynchronous sensors)
- H, M, L  in  1 each  tank level probes high / mid / low (asynchronous)
- Vs  out  1  drip valve open
- Bs  out  1  sprinkler open
- Ve  out  1  tank inlet valve open
- Al  out  1  alarm
- Cheio, Medio, Baixo, Vazio, Erro  out  1 each  registered tank-state flags
- estado  out  3  FSM state: 0 OCIOSO, 1 GOTEJA, 2 ASPERSAO, 3 PAUSA, 4 FALHA

## Operation
- Input path per sensor: 2-flop synchronizer feeds the debouncer. The debounce counter increments while the synced value differs from the debounced value and clears when they are equal. The debounced value updates, and the counter clears, on the cycle the counter would reach DEB_CYC.
- Level decode, registered from debounced values (suffix _d):
  - Cheio = H·M·L
  - Medio = ~H·M·L
  - Baixo = ~H·~M·L
  - Vazio = ~H·~M·~L
  - Erro = M·~L + H·~M
- Requests, combinational from the registered flags and debounced sensors:
  - req_g = ~Us·Ua·~Erro·~Vazio·(T + Baixo)
  - req_a = ~Us·~Erro·~Vazio·(~Ua + ~T·Medio)
  - The two requests are mutually exclusive by construction.
- FSM:
  - OCIOSO: Erro → FALHA; else req_g → GOTEJA; else req_a → ASPERSAO. The timer clears on entry to any run state.
  - GOTEJA / ASPERSAO: valve open and timer increments each cycle.
    - Erro → FALHA immediately, ignoring MIN_ON.
    - Else Vazio → PAUSA immediately.
    - Else timer = MAX_ON−1 → PAUSA, and sticky flag tmo is set.
    - Else own request low and timer ≥ MIN_ON−1 → PAUSA.
    - The opposite request never preempts a running valve.
  - PAUSA: both valves closed for GAP cycles, then OCIOSO (or FALHA if Erro).
  - FALHA: Vs = Bs = Ve = 0. Exits to PAUSA on the first cycle Erro = 0.
- Outputs decoded from the state register: Vs = (estado == GOTEJA), Bs = (estado == ASPERSAO). Vs·Bs is never 1.
- Ve: a registered set/reset.
  - Set when (Vazio + Baixo)·~Erro.
  - Cleared when Cheio + Erro, or when in FALHA.
  - Holds its value while Medio.
- Al = ~M_d + ~L_d + Erro + tmo. tmo clears when Us_d = 1 or on reset.

## Timing
- Reset (async assert, sync release) sets:
  - state OCIOSO, timers 0, tmo 0;
  - synchronizers, debounced values and debounce counters 0;
  - flags: Vazio = 1, Cheio = Medio = Baixo = Erro = 0;
  - Vs = Bs = Ve = 0;
  - Al = 1, because debounced M = L = 0.
- Ve becomes 1 one cycle after reset release (Vazio set).
- Latency: a sensor change stable from edge n affects a valve output at edge n + DEB_CYC + 4. That is 2 synchronizer cycles, DEB_CYC debounce cycles, 1 decode cycle and 1 FSM cycle.
- Glitches shorter than DEB_CYC cycles after synchronization produce no change.
- Run length: minimum MIN_ON cycles unless aborted by Erro/Vazio; maximum MAX_ON cycles.
- Between any two valve openings there are at least GAP cycles with Vs = Bs = 0.
- Reset mid-run closes the valve asynchronously.
- When the request drops and MIN_ON is reached in the same cycle, the block exits to PAUSA.
- Erro and Vazio in the same cycle go to FALHA.

## Test plan
Defaults: DEB_CYC=4, MIN_ON=16, MAX_ON=255, GAP=2.
- Reset then H=M=L=0: Vazio=1 and Ve=1 one cycle after reset release; Al=1; estado=0. Raise L, M, H in turn: Ve stays 1 through Baixo/Medio and drops 8 cycles after H rises (Cheio).
- Tank Medio, Us=0, Ua=1, T=1: Vs rises exactly 8 cycles after the inputs change. Set T=0 after 3 cycles: Vs stays open 16 cycles total, then PAUSA; Bs=1 after 2 closed cycles (req_a via Medio).
- Ua toggles for 3 cycles (pulse < DEB_CYC) during OCIOSO: no valve, debounced, or estado change.
- Drip running and req_g held for 300 cycles: Vs closes after 255 cycles; Al=1 via tmo; Vs reopens after GAP; tmo clears when Us=1 is debounced.
- Sprinkler running, then M=1, L=0 (Erro): estado=4 and Bs=Ve=0 after 8 cycles despite MIN_ON. Restore M=L=1: PAUSA then OCIOSO.
- rst pulsed mid-run: Vs/Bs fall with no clock edge; all outputs take their reset values.
